io_checkpoint_monitor: RTL

Synthesizable in-design checker that consumes the checkpoint code (mprj_io[31:16]) and status nibble (mprj_io[35:32]) driven by management firmware during user-project stimulus tests. It synchronizes and filters both buses, walks a programmable sequence: start code, status A, status B, N masked step codes, end code. It raises sticky pass or fail with a per-stage timeout, so silicon bring-up can self-check without a simulator monitor.

---
 rtl/io_checkpoint_monitor.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/io_checkpoint_monitor.sv
// Pad checkpoint monitor: synchronises and debounces the firmware code/status buses and walks
// start -> status A -> status B -> masked steps -> end, with sticky pass/fail and per-stage timeout.
module io_checkpoint_monitor #(
    parameter int unsigned CODE_W        = 16,
    parameter int unsigned STAT_W        = 4,
    parameter int unsigned NUM_STEPS     = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TMO_W         = 24
) (
    input  logic                               clock,
    input  logic                               resetb,
    input  logic                               enable,
    input  logic [CODE_W-1:0]                  checkbits_in,
    input  logic [STAT_W-1:0]                  status_in,
    input  logic [CODE_W-1:0]                  start_code,
    input  logic [STAT_W-1:0]                  stat_a,
    input  logic [STAT_W-1:0]                  stat_b,
    input  logic [NUM_STEPS*CODE_W-1:0]        step_code,
    input  logic [NUM_STEPS*CODE_W-1:0]        step_mask,
    input  logic [$clog2(NUM_STEPS+1)-1:0]     steps_used,
    input  logic [CODE_W-1:0]                  end_code,
    input  logic [TMO_W-1:0]                   timeout_limit,
    output logic                               busy,
    output logic                               pass,
    output logic                               fail,
    output logic [2:0]                         fail_stage,
    output logic [$clog2(NUM_STEPS+1)-1:0]     step_idx,
    output logic [CODE_W-1:0]                  last_code
);

    localparam int unsigned SW = $clog2(NUM_STEPS + 1);
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitStart = 3'd1,
        StWaitStatA = 3'd2,
        StWaitStatB = 3'd3,
        StMatch     = 3'd4,
        StWaitEnd   = 3'd5,
        StDonePass  = 3'd6,
        StDoneFail  = 3'd7
    } state_e;

    state_e state;

    logic [CODE_W-1:0] code_s1, code_s2, code_prev;
    logic [STAT_W-1:0] stat_s1, stat_s2, stat_prev;
    logic [CW-1:0]     code_cnt, code_cnt_d, stat_cnt, stat_cnt_d;
    logic              code_diff, code_acc, code_new;
    logic              stat_diff, stat_acc;

    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              step_armed;
    logic              step_hit;
    logic              last_step;
    logic              adv;
    logic [SW-1:0]     steps_eff;
    logic [CODE_W-1:0] cur_code, cur_mask;

    // Acceptance is evaluated on the counter's next value so the FSM and last_code react on the
    // same edge the value becomes stable (2 + STABLE_CYCLES after a pad change).
    always_comb begin
        code_diff = code_s2 != code_prev;
        if (code_diff) begin
            code_cnt_d = CW'(1);
        end else if (code_cnt == STABLE_MAX) begin
            code_cnt_d = code_cnt;
        end else begin
            code_cnt_d = code_cnt + CW'(1);
        end
        code_acc = code_cnt_d == STABLE_MAX;
        code_new = code_acc && (code_diff || code_cnt != STABLE_MAX);

        stat_diff = stat_s2 != stat_prev;
        if (stat_diff) begin
            stat_cnt_d = CW'(1);
        end else if (stat_cnt == STABLE_MAX) begin
            stat_cnt_d = stat_cnt;
        end else begin
            stat_cnt_d = stat_cnt + CW'(1);
        end
        stat_acc = stat_cnt_d == STABLE_MAX;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            code_s1   <= '0;
            code_s2   <= '0;
            code_prev <= '0;
            code_cnt  <= '0;
            stat_s1   <= '0;
            stat_s2   <= '0;
            stat_prev <= '0;
            stat_cnt  <= '0;
            last_code <= '0;
        end else begin
            code_s1   <= checkbits_in;
            code_s2   <= code_s1;
            code_prev <= code_s2;
            code_cnt  <= code_cnt_d;
            stat_s1   <= status_in;
            stat_s2   <= stat_s1;
            stat_prev <= stat_s2;
            stat_cnt  <= stat_cnt_d;
            if (code_acc) begin
                last_code <= code_s2;
            end
        end
    end

    always_comb begin
        steps_eff = (steps_used > SW'(NUM_STEPS)) ? SW'(NUM_STEPS) : steps_used;
        cur_code  = '0;
        cur_mask  = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (step_idx == SW'(i)) begin
                cur_code = step_code[i*CODE_W +: CODE_W];
                cur_mask = step_mask[i*CODE_W +: CODE_W];
            end
        end
        // A step needs an armed comparator: armed on MATCH entry or by a fresh acceptance.
        step_hit  = code_acc && (step_armed || code_new) &&
                    ((code_s2 & cur_mask) == (cur_code & cur_mask));
        last_step = (step_idx + SW'(1)) == steps_eff;
        tmo_hit   = (timeout_limit != '0) && ((tmo_cnt + TMO_W'(1)) == timeout_limit);

        adv = 1'b0;
        unique case (state)
            StWaitStart: adv = code_acc && (code_s2 == start_code);
            StWaitStatA: adv = stat_acc && (stat_s2 == stat_a);
            StWaitStatB: adv = stat_acc && (stat_s2 == stat_b);
            StMatch:     adv = step_hit;
            StWaitEnd:   adv = code_acc && (code_s2 == end_code);
            StIdle, StDonePass, StDoneFail: adv = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb || !enable) begin
            state      <= StIdle;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_stage <= '0;
            step_idx   <= '0;
            tmo_cnt    <= '0;
            step_armed <= 1'b0;
        end else begin
            tmo_cnt <= busy ? tmo_cnt + TMO_W'(1) : '0;
            unique case (state)
                StIdle: begin
                    state   <= StWaitStart;
                    busy    <= 1'b1;
                    tmo_cnt <= '0;
                end
                StWaitStart: begin
                    if (adv) begin
                        state   <= StWaitStatA;
                        tmo_cnt <= '0;
                    end
                end
                StWaitStatA: begin
                    if (adv) begin
                        state   <= StWaitStatB;
                        tmo_cnt <= '0;
                    end
                end
                StWaitStatB: begin
                    if (adv) begin
                        step_idx   <= '0;
                        step_armed <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= (steps_eff != '0) ? StMatch : StWaitEnd;
                    end
                end
                StMatch: begin
                    if (adv) begin
                        step_idx   <= step_idx + SW'(1);
                        step_armed <= 1'b0;
                        if (last_step) begin
                            state   <= StWaitEnd;
                            tmo_cnt <= '0;
                        end
                    end else if (code_new) begin
                        step_armed <= 1'b1;
                    end
                end
                StWaitEnd: begin
                    if (adv) begin
                        state <= StDonePass;
                        pass  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                StDonePass, StDoneFail: begin
                end
            endcase
            // Progress wins over a timeout landing in the same cycle.
            if (busy && !adv && tmo_hit) begin
                state      <= StDoneFail;
                fail       <= 1'b1;
                fail_stage <= state;
                busy       <= 1'b0;
            end
        end
    end

endmodule
